// File: rtl/mem_port_arbiter_if.sv
// Purpose : bundle of fetch port, data port and memory port signals
//           shared between the pipeline/memory side and mem_port_arbiter.
// Signals : if_req/if_addr/if_gnt/if_rvalid/if_rdata        fetch port
//           dm_req/dm_addr/dm_w_mask/dm_wdata/dm_gnt/
//           dm_rvalid/dm_rdata                              data port
//           mem_en/mem_addr/mem_w_mask/mem_wdata/mem_rdata  memory port
//           busy                                            transaction outstanding
// Modports: slave  - the arbiter
//           master - the pipeline and memory around it
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [7:0]        dm_w_mask;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_w_mask;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_w_mask, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_addr, mem_w_mask, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_w_mask, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               mem_en, mem_addr, mem_w_mask, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported memory between the fetch port and the
//           data port. One transaction in flight; data wins by default, a
//           starvation counter forces a fetch grant after STARVE_MAX
//           consecutive data grants with a fetch waiting.
// Ports   : clk  - clock
//           rst  - asynchronous, active-high reset
//           bus  - mem_port_arbiter_if.slave (fetch, data and memory ports)
//           if_gnt/dm_gnt and mem_en/mem_addr/mem_w_mask/mem_wdata are
//           combinational from the issue decision; rdata/rvalid are registered.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [STV_W-1:0]  r_starve_cnt;
    logic              r_win_if;
    logic              r_is_store;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;

    logic [1:0]        w_next_state;
    logic              w_if_gnt;
    logic              w_dm_gnt;
    logic              w_issue;
    logic              w_starved;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [7:0]        w_mem_w_mask;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_starved = (r_starve_cnt == STV_W'(STARVE_MAX));
    assign w_issue   = w_if_gnt | w_dm_gnt;

    // Next state, arbitration and memory request mux.
    // Grants are gated by rst so every output stays low while reset is held.
    always_comb begin
        w_next_state = r_state;
        w_if_gnt     = 1'b0;
        w_dm_gnt     = 1'b0;
        w_mem_addr   = '0;
        w_mem_w_mask = '0;
        w_mem_wdata  = '0;

        case (r_state)
            S_IDLE, S_RESP: begin
                if (!rst) begin
                    if (bus.if_req && (!bus.dm_req || w_starved)) begin
                        w_if_gnt = 1'b1;
                    end else if (bus.dm_req) begin
                        w_dm_gnt = 1'b1;
                    end
                end
                w_next_state = (w_if_gnt || w_dm_gnt) ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (r_lat_cnt == '0) begin
                    w_next_state = S_RESP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        if (w_dm_gnt) begin
            w_mem_addr   = ADDR_W'(bus.dm_addr);
            w_mem_w_mask = bus.dm_w_mask;
            w_mem_wdata  = DATA_W'(bus.dm_wdata);
        end else if (w_if_gnt) begin
            w_mem_addr   = ADDR_W'(bus.if_addr);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Transaction bookkeeping, latency countdown and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_win_if     <= 1'b0;
            r_is_store   <= 1'b0;
            r_if_rvalid  <= 1'b0;
            r_dm_rvalid  <= 1'b0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;

            if (w_issue) begin
                r_win_if   <= w_if_gnt;
                r_is_store <= w_dm_gnt && (bus.dm_w_mask != 8'h00);
                r_lat_cnt  <= LAT_W'(MEM_LAT - 1);
            end else if (r_state == S_WAIT) begin
                if (r_lat_cnt != '0) begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                end else if (r_win_if) begin
                    r_if_rdata  <= DATA_W'(bus.mem_rdata);
                    r_if_rvalid <= 1'b1;
                end else begin
                    // Stores complete with zero data.
                    r_dm_rdata  <= r_is_store ? '0 : DATA_W'(bus.mem_rdata);
                    r_dm_rvalid <= 1'b1;
                end
            end

            // Counts data grants taken while a fetch waits; saturates.
            if (w_if_gnt) begin
                r_starve_cnt <= '0;
            end else if (w_dm_gnt && bus.if_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + STV_W'(1);
            end
        end
    end

    assign bus.if_gnt     = w_if_gnt;
    assign bus.dm_gnt     = w_dm_gnt;
    assign bus.mem_en     = w_issue;
    assign bus.mem_addr   = w_mem_addr;
    assign bus.mem_w_mask = w_mem_w_mask;
    assign bus.mem_wdata  = w_mem_wdata;
    assign bus.if_rvalid  = r_if_rvalid;
    assign bus.dm_rvalid  = r_dm_rvalid;
    assign bus.if_rdata   = r_if_rdata;
    assign bus.dm_rdata   = r_dm_rdata;
    assign bus.busy       = (r_state == S_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LAT=2, STARVE_MAX=4.
// Inputs are driven at the falling edge; outputs are sampled 1 ns later.
// "Cycle c" of a scenario is the clock period whose falling edge is the
// c-th one after the scenario starts.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: data appears two cycles after the mem_en cycle.
    function automatic logic [63:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 64'h0000_0000_DEAD_BEEF;
        return 64'h1111_0000_0000_0000 | 64'(a);
    endfunction

    logic [1:0]  pv;
    logic [31:0] pa0, pa1;
    always @(posedge clk) begin
        pv[0] <= bus.mem_en;
        pa0   <= bus.mem_addr;
        pv[1] <= pv[0];
        pa1   <= pa0;
    end
    assign bus.mem_rdata = (pv[1] === 1'b1) ? mem_fn(pa1) : 64'h0;

    // {if_gnt, dm_gnt, mem_en, busy, if_rvalid, dm_rvalid}
    logic [5:0] st;
    assign st = {bus.if_gnt, bus.dm_gnt, bus.mem_en, bus.busy, bus.if_rvalid, bus.dm_rvalid};

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_w_mask = '0;
        bus.dm_wdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        bus.dm_addr = 32'h44;
        #1;
        n_cmp++;
        if (st !== 6'b000000) begin
            n_err++; $display("FAIL reset_status: got %b want 000000", st);
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_w_mask, bus.mem_wdata} !== '0) begin
            n_err++; $display("FAIL reset_mem_bus: got %h/%h/%h want 0", bus.mem_addr, bus.mem_w_mask, bus.mem_wdata);
        end
        n_cmp++;
        if ({bus.if_rdata, bus.dm_rdata} !== '0) begin
            n_err++; $display("FAIL reset_rdata: got %h/%h want 0", bus.if_rdata, bus.dm_rdata);
        end
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        logic [5:0] exp_st [5];
        exp_st = '{6'b101000, 6'b000100, 6'b000100, 6'b000010, 6'b000000};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.if_req  = (c == 1);
            bus.if_addr = 32'h100;
            #1;
            n_cmp++;
            if (st !== exp_st[c-1]) begin
                n_err++; $display("FAIL single_status c%0d: got %b want %b", c, st, exp_st[c-1]);
            end
            if (c == 1) begin
                n_cmp++;
                if (bus.mem_addr !== 32'h100 || bus.mem_w_mask !== 8'h0 || bus.mem_wdata !== 64'h0) begin
                    n_err++; $display("FAIL single_mem_bus: got %h/%h/%h want 100/00/0", bus.mem_addr, bus.mem_w_mask, bus.mem_wdata);
                end
            end
            if (c >= 4) begin
                n_cmp++;
                if (bus.if_rdata !== 64'hDEAD_BEEF) begin
                    n_err++; $display("FAIL single_rdata c%0d: got %h want deadbeef", c, bus.if_rdata);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp_st [8];
        exp_st = '{6'b011000, 6'b000100, 6'b000100, 6'b101001,
                   6'b000100, 6'b000100, 6'b000010, 6'b000000};
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.dm_req  = (c == 1);
            bus.dm_addr = 32'h200;
            bus.if_req  = (c <= 4);
            bus.if_addr = 32'h300;
            #1;
            n_cmp++;
            if (st !== exp_st[c-1]) begin
                n_err++; $display("FAIL simul_status c%0d: got %b want %b", c, st, exp_st[c-1]);
            end
            if (c == 1 || c == 4) begin
                n_cmp++;
                if (bus.mem_addr !== ((c == 1) ? 32'h200 : 32'h300)) begin
                    n_err++; $display("FAIL simul_mem_addr c%0d: got %h", c, bus.mem_addr);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (bus.dm_rdata !== 64'h1111_0000_0000_0200) begin
                    n_err++; $display("FAIL simul_dm_rdata: got %h want 1111000000000200", bus.dm_rdata);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (bus.if_rdata !== 64'h1111_0000_0000_0300) begin
                    n_err++; $display("FAIL simul_if_rdata: got %h want 1111000000000300", bus.if_rdata);
                end
            end
        end
    endtask

    task automatic test_starvation();
        logic [5:0] exp;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.if_req  = (c <= 16);
            bus.if_addr = 32'h90;
            bus.dm_req  = (c <= 16);
            bus.dm_addr = 32'h80;
            #1;
            exp = '0;
            if (c == 13) exp[5] = 1'b1;
            if (c == 1 || c == 4 || c == 7 || c == 10 || c == 16) exp[4] = 1'b1;
            exp[3] = exp[5] | exp[4];
            exp[2] = (c % 3 != 1) && (c <= 18);
            exp[1] = (c == 16);
            exp[0] = (c == 4 || c == 7 || c == 10 || c == 13 || c == 19);
            n_cmp++;
            if (st !== exp) begin
                n_err++; $display("FAIL starve_status c%0d: got %b want %b", c, st, exp);
            end
        end
        n_cmp++;
        if (bus.if_rdata !== 64'h1111_0000_0000_0090 || bus.dm_rdata !== 64'h1111_0000_0000_0080) begin
            n_err++; $display("FAIL starve_rdata: got %h/%h want ..0090/..0080", bus.if_rdata, bus.dm_rdata);
        end
    endtask

    task automatic test_store();
        logic [5:0] exp_st [5];
        exp_st = '{6'b011000, 6'b000100, 6'b000100, 6'b000001, 6'b000000};
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.dm_req    = (c == 1);
            bus.dm_addr   = 32'h40;
            bus.dm_w_mask = 8'h0F;
            bus.dm_wdata  = 64'h1122_3344_5566_7788;
            #1;
            n_cmp++;
            if (st !== exp_st[c-1]) begin
                n_err++; $display("FAIL store_status c%0d: got %b want %b", c, st, exp_st[c-1]);
            end
            n_cmp++;
            if (c == 1) begin
                if (bus.mem_addr !== 32'h40 || bus.mem_w_mask !== 8'h0F || bus.mem_wdata !== 64'h1122_3344_5566_7788) begin
                    n_err++; $display("FAIL store_mem_bus: got %h/%h/%h", bus.mem_addr, bus.mem_w_mask, bus.mem_wdata);
                end
            end else if ({bus.mem_addr, bus.mem_w_mask, bus.mem_wdata} !== '0) begin
                n_err++; $display("FAIL store_mem_idle c%0d: got %h/%h/%h want 0", c, bus.mem_addr, bus.mem_w_mask, bus.mem_wdata);
            end
            if (c == 4) begin
                n_cmp++;
                if (bus.dm_rdata !== 64'h0 || bus.if_rdata !== 64'h1111_0000_0000_0090) begin
                    n_err++; $display("FAIL store_rdata: got dm %h if %h want 0/..0090", bus.dm_rdata, bus.if_rdata);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        logic [5:0] exp_st [8];
        exp_st = '{6'b101000, 6'b000000, 6'b000000, 6'b101000,
                   6'b000100, 6'b000100, 6'b000010, 6'b000000};
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rst         = (c == 2 || c == 3);
            bus.if_req  = (c <= 4);
            bus.if_addr = 32'h500;
            #1;
            n_cmp++;
            if (st !== exp_st[c-1]) begin
                n_err++; $display("FAIL rstwait_status c%0d: got %b want %b", c, st, exp_st[c-1]);
            end
            if (c == 2) begin
                n_cmp++;
                if ({bus.mem_addr, bus.if_rdata, bus.dm_rdata} !== '0) begin
                    n_err++; $display("FAIL rstwait_outputs: got %h/%h/%h want 0", bus.mem_addr, bus.if_rdata, bus.dm_rdata);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (bus.mem_addr !== 32'h500) begin
                    n_err++; $display("FAIL rstwait_mem_addr: got %h want 500", bus.mem_addr);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (bus.if_rdata !== 64'h1111_0000_0000_0500) begin
                    n_err++; $display("FAIL rstwait_rdata: got %h want 1111000000000500", bus.if_rdata);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [4];
        logic [5:0]  exp;
        int          idx;
        int          rv_idx;
        addrs  = '{32'h0, 32'h8, 32'h10, 32'h18};
        idx    = 0;
        rv_idx = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            bus.if_req  = (idx < 4);
            bus.if_addr = addrs[idx % 4];
            #1;
            exp    = '0;
            exp[5] = (c % 3 == 1) && (c <= 10);
            exp[3] = exp[5];
            exp[2] = (c % 3 != 1) && (c <= 12);
            exp[1] = (c % 3 == 1) && (c >= 4) && (c <= 13);
            n_cmp++;
            if (st !== exp) begin
                n_err++; $display("FAIL b2b_status c%0d: got %b want %b", c, st, exp);
            end
            if (exp[5]) begin
                n_cmp++;
                if (bus.mem_addr !== addrs[idx]) begin
                    n_err++; $display("FAIL b2b_mem_addr c%0d: got %h want %h", c, bus.mem_addr, addrs[idx]);
                end
                idx++;
            end
            if (exp[1]) begin
                n_cmp++;
                if (bus.if_rdata !== (64'h1111_0000_0000_0000 | 64'(addrs[rv_idx]))) begin
                    n_err++; $display("FAIL b2b_rdata c%0d: got %h for addr %h", c, bus.if_rdata, addrs[rv_idx]);
                end
                rv_idx++;
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store();
        test_reset_mid_wait();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch port and the data (load/store) port of the RV64I pipeline.
- Issues one transaction at a time to memory, waits a fixed memory latency and returns read data to the winning requester with a one-cycle valid pulse.
- Data requests win by default. A starvation counter guarantees fetch progress.
- The pipeline controller uses if_gnt and dm_gnt to generate stalls.

Parameters:
- ADDR_W, 32: byte address width on all ports.
- DATA_W, 64: data width.
- MEM_LAT, 2: cycles from the issue cycle to mem_rdata being valid. Must be >= 1.
- STARVE_MAX, 4: maximum consecutive data grants while a fetch request is waiting.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetched data (registered)
- dm_req  in  1  data request; held with dm_addr, dm_w_mask and dm_wdata stable until dm_gnt
- dm_addr  in  ADDR_W  data address
- dm_w_mask  in  8  byte write mask; 0 means load
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  data accepted this cycle (combinational)
- dm_rvalid  out  1  one-cycle pulse; load data or store completion
- dm_rdata  out  DATA_W  load data (registered); 0 for stores
- mem_en  out  1  memory access strobe, one cycle per transaction
- mem_addr  out  ADDR_W  memory address
- mem_w_mask  out  8  memory byte write mask
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
- busy  out  1  a transaction is outstanding (state WAIT)

Behaviour:

States:
- IDLE: accepts requests.
- WAIT: counts down the memory latency.
- RESP: delivers the response and accepts requests.

Issue (state IDLE or RESP, at least one req high):
- Select a winner. Assert its gnt and mem_en in the same cycle.
- mem_addr, mem_w_mask and mem_wdata come combinationally from the winner. mem_w_mask and mem_wdata are 0 for a fetch.
- Latch the winner id and the load/store flag. Load lat_cnt = MEM_LAT-1. Go to WAIT.

Outside the issue cycle:
- mem_en = 0.
- mem_addr, mem_w_mask and mem_wdata are driven to 0.

Arbitration:
- dm wins unless starve_cnt == STARVE_MAX and if_req = 1; in that case if wins.

starve_cnt (width clog2(STARVE_MAX+1)):
- Increments on a dm grant while if_req = 1.
- Clears on any if grant.
- Never exceeds STARVE_MAX.

WAIT:
- While lat_cnt != 0, decrement lat_cnt.
- When lat_cnt == 0 (the cycle mem_rdata is valid):
  - capture mem_rdata into the winner's rdata register (store: capture 0);
  - go to RESP.

RESP:
- Pulse the winner's rvalid for exactly one cycle.
- The non-winner's rdata register keeps its prior value.
- If a req is high, issue in this same cycle (go to WAIT); otherwise go to IDLE.

Timing:
- With the issue at cycle T, rvalid is asserted at T+MEM_LAT+1.
- Back-to-back throughput is one transaction per MEM_LAT+1 cycles.

Request handling:
- Requests arriving in WAIT get no gnt and must be held.
- Dropping req before gnt is legal; no transaction occurs.
- if_gnt and dm_gnt are never both high.
- At most one rvalid is high per cycle.
- if_rvalid/dm_rvalid and the corresponding gnt may be high in the same cycle (RESP re-issue).

busy:
- 1 exactly in WAIT.

Reset:
- Every output is 0; state IDLE; lat_cnt, starve_cnt and winner id are 0.
- Reset asserted mid-transaction abandons the outstanding response: no rvalid is produced after reset.
- The first req after reset release is granted in that cycle.

Test Plan:
1. Single fetch:
   - Stimulus: MEM_LAT=2; if_req=1, if_addr=0x100 at cycle 1; mem_rdata=0xDEAD_BEEF at cycle 3.
   - Required: if_gnt=mem_en=1 and mem_addr=0x100, mem_w_mask=0 at cycle 1; busy=1 cycles 2-3; if_rvalid=1 with if_rdata=0xDEAD_BEEF at cycle 4 only.
2. Simultaneous requests:
   - Stimulus: if_req=dm_req=1 at cycle 1 (dm load addr 0x200).
   - Required: dm_gnt at cycle 1; dm_rvalid and if_gnt together at cycle 4; if_rvalid at cycle 7.
3. Starvation:
   - Stimulus: STARVE_MAX=4; dm_req and if_req held high continuously.
   - Required: dm_gnt at cycles 1, 4, 7, 10; if_gnt at cycle 13; dm_gnt again at cycle 16.
4. Store:
   - Stimulus: dm_w_mask=0x0F, dm_wdata=0x1122334455667788, dm_addr=0x40.
   - Required: mem_en=1 with mem_w_mask=0x0F and matching mem_wdata/mem_addr for exactly one cycle; dm_rvalid=1 with dm_rdata=0 at T+3.
5. Reset mid-WAIT:
   - Stimulus: issue a fetch at cycle 1; rst pulse at cycle 2; if_req still high after release.
   - Required: all outputs 0 during reset; no if_rvalid for the aborted fetch; if_gnt in the first cycle after release.
6. Back-to-back fetches:
   - Stimulus: if_req held for 4 transactions with addresses 0x0, 0x8, 0x10, 0x18.
   - Required: gnt every 3 cycles; 4 if_rvalid pulses in issue order with matching data; busy never high in an issue cycle.
